// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared types and helpers for the pipelined adder/subtractor family.
//   addsub_op_t  : operation tag carried down the pipeline with each operand set
//   chunk_width  : bits resolved per pipeline stage (WIDTH / STAGES)
// ----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } addsub_op_t;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// ----------------------------------------------------------------------------
// add_chunk
// Combinational CW-bit carry-lookahead adder used for one pipeline stage.
// Ports:
//   a, b : CW-bit chunk operands
//   ci   : carry into the chunk
//   s    : CW-bit chunk sum
//   co   : carry out of the chunk MSB
// ----------------------------------------------------------------------------
module add_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co
);

    logic [CW-1:0] gen;
    logic [CW-1:0] prop;
    logic [CW:0]   carry;
    logic          term;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is built directly from generate/propagate terms and ci
    // rather than from the previous carry, so no ripple chain is formed.
    always_comb begin
        carry    = '0;
        term     = 1'b0;
        carry[0] = ci;
        for (int i = 0; i < CW; i++) begin
            term = ci;
            for (int j = 0; j <= i; j++) begin
                term = term & prop[j];
            end
            carry[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = gen[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & prop[k];
                end
                carry[i+1] = carry[i+1] | term;
            end
        end
    end

    assign s  = prop ^ carry[CW-1:0];
    assign co = carry[CW];

endmodule

// File: rtl/pipelined_add_sub.sv
// ----------------------------------------------------------------------------
// pipelined_add_sub
// Pipelined two's-complement adder/subtractor. The WIDTH-bit operation is
// split into STAGES chunks; stage k resolves chunk k and registers its carry
// for stage k+1. Valid/ready handshake on both sides, one op per cycle.
// Ports:
//   clk, rst_n          : rising-edge clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake
//   a, b, sub, cin      : operands; sub=1 computes a-b-cin (cin = borrow-in)
//   out_valid/out_ready : result handshake
//   sum, cout, overflow : result, carry/borrow-out, signed overflow
// ----------------------------------------------------------------------------
module pipelined_add_sub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW   = chunk_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;
    localparam int MSB  = WIDTH - 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_split
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // Inputs seen by each stage: stage 0 takes the prepared operands, every
    // later stage takes the registers written by the stage before it.
    logic [WIDTH-1:0] st_a  [STAGES];
    logic [WIDTH-1:0] st_b  [STAGES];
    logic [WIDTH-1:0] st_s  [STAGES];
    logic             st_c  [STAGES];
    logic             st_v  [STAGES];
    addsub_op_t       st_op [STAGES];

    // Registers written by each stage.
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];
    addsub_op_t       op_q  [STAGES];

    logic [STAGES-1:0][CW-1:0] chunk_s;
    logic [STAGES-1:0]         chunk_c;
    logic                      advance;
    logic                      raw_c;

    // Subtraction is a + ~b + ~cin, so inverting b and the borrow-in turns
    // the whole pipeline into a plain adder.
    always_comb begin
        st_a[0]  = a;
        st_b[0]  = sub ? ~b : b;
        st_s[0]  = '0;
        st_c[0]  = sub ? ~cin : cin;
        st_v[0]  = in_valid;
        st_op[0] = sub ? OP_SUB : OP_ADD;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k]  = a_q[k-1];
            st_b[k]  = b_q[k-1];
            st_s[k]  = s_q[k-1];
            st_c[k]  = c_q[k-1];
            st_v[k]  = v_q[k-1];
            st_op[k] = op_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_chunk #(
            .CW (CW)
        ) u_chunk (
            .a  (st_a[k][k*CW +: CW]),
            .b  (st_b[k][k*CW +: CW]),
            .ci (st_c[k]),
            .s  (chunk_s[k]),
            .co (chunk_c[k])
        );
    end

    // The whole pipeline moves as one; a stalled output freezes every stage.
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= st_v[k];
            end
        end
    end

    // Data registers carry no reset; stale contents are masked at the outputs.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]                <= st_a[k];
                b_q[k]                <= st_b[k];
                s_q[k]                <= st_s[k];
                s_q[k][k*CW +: CW]    <= chunk_s[k];
                c_q[k]                <= chunk_c[k];
                op_q[k]               <= st_op[k];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign raw_c     = c_q[LAST];

    // For subtraction the adder carry means "no borrow", hence the inversion.
    always_comb begin
        sum      = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        if (out_valid) begin
            sum      = s_q[LAST];
            cout     = (op_q[LAST] == OP_SUB) ? ~raw_c : raw_c;
            overflow = (a_q[LAST][MSB] == b_q[LAST][MSB]) &&
                       (s_q[LAST][MSB] != a_q[LAST][MSB]);
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// ----------------------------------------------------------------------------
// tb_pipelined_add_sub
// Scoreboard bench for pipelined_add_sub: stimulus pushes expected results
// from an arithmetic reference model; a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
);

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        int               acc_cyc;
        bit               chk_lat;
    } exp_t;

    localparam logic [WIDTH-1:0] ALL1   = '1;
    localparam logic [WIDTH-1:0] MAXPOS = ALL1 >> 1;
    localparam logic [WIDTH-1:0] MINNEG = ~MAXPOS;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc          = 0;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    bit   ready_mode   = 1'b0;
    int   ready_idx    = 0;

    pipelined_add_sub #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on widened values.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic sv, input logic cv);
        exp_t        e;
        longint      ua, ub, sa, sb, ci, full, sres, lim, hi, lo;
        logic [63:0] fv;
        ua   = longint'(av);
        ub   = longint'(bv);
        sa   = longint'($signed(av));
        sb   = longint'($signed(bv));
        ci   = longint'(cv);
        lim  = longint'(1) <<< WIDTH;
        hi   = (longint'(1) <<< (WIDTH - 1)) - 1;
        lo   = -(longint'(1) <<< (WIDTH - 1));
        if (!sv) begin
            full = ua + ub + ci;
            sres = sa + sb + ci;
            e.c  = (full >= lim);
        end else begin
            full = ua - ub - ci;
            sres = sa - sb - ci;
            e.c  = (ua < ub + ci);
        end
        fv        = full;
        e.s       = fv[WIDTH-1:0];
        e.o       = (sres > hi) || (sres < lo);
        e.acc_cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o);
        exp_t e;
        e.s       = s;
        e.c       = c;
        e.o       = o;
        e.acc_cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    // Consumer side: out_ready either held high or cycling 1,0,0,1.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                out_ready = ((ready_idx % 4) == 0) || ((ready_idx % 4) == 3);
                ready_idx++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: while stalled the front result must be held; on drain it is popped.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
                mon_e = exp_q[0];
                checkOutput("sum", 64'(sum), 64'(mon_e.s));
                checkOutput("cout", 64'(cout), 64'(mon_e.c));
                checkOutput("overflow", 64'(overflow), 64'(mon_e.o));
                if (!out_ready) begin
                    checkOutput("in_ready_stall", 64'(in_ready), 64'(0));
                end else begin
                    if (mon_e.chk_lat) begin
                        checkOutput("latency", 64'(cyc - mon_e.acc_cyc), 64'(STAGES));
                    end
                    mon_e = exp_q.pop_front();
                end
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic sv, input logic cv, input exp_t e);
        int waited = 0;
        bit done   = 1'b0;
        a        = av;
        b        = bv;
        sub      = sv;
        cin      = cv;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc_cyc = cyc;
                e.chk_lat = !ready_mode;
                exp_q.push_back(e);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    checkOutput("accept_timeout", 64'(0), 64'(1));
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic applyRandom(input bit allow_bubble);
        logic [63:0]      r;
        logic [WIDTH-1:0] av, bv;
        logic             sv, cv;
        r  = {$urandom, $urandom};
        av = r[WIDTH-1:0];
        r  = {$urandom, $urandom};
        bv = r[WIDTH-1:0];
        sv = 1'($urandom_range(0, 1));
        cv = 1'($urandom_range(0, 1));
        applyStimulus(av, bv, sv, cv, model(av, bv, sv, cv));
        if (allow_bubble && ($urandom_range(0, 3) == 0)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain();
        int t = 0;
        while ((exp_q.size() != 0) && (t < 1000)) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sub      = 1'b0;
        cin      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_sum", 64'(sum), 64'(0));
        checkOutput("reset_cout", 64'(cout), 64'(0));
        checkOutput("reset_overflow", 64'(overflow), 64'(0));
        checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Directed corner cases with hand-derived results.
        applyStimulus(WIDTH'(16'h00FF), WIDTH'(1), 1'b0, 1'b0, mk(WIDTH'(16'h0100), 1'b0, 1'b0));
        applyStimulus(MAXPOS, WIDTH'(1), 1'b0, 1'b0, mk(MINNEG, 1'b0, 1'b1));
        applyStimulus(ALL1, ALL1, 1'b0, 1'b1, mk(ALL1, 1'b1, 1'b0));
        applyStimulus(WIDTH'(0), WIDTH'(1), 1'b1, 1'b0, mk(ALL1, 1'b1, 1'b0));
        applyStimulus(MINNEG, WIDTH'(1), 1'b1, 1'b0, mk(MAXPOS, 1'b0, 1'b1));
        applyStimulus(WIDTH'(5), WIDTH'(3), 1'b1, 1'b1, mk(WIDTH'(1), 1'b0, 1'b0));
        waitDrain();

        $display("[TB] random operations, consumer always ready");
        for (int i = 0; i < 1000; i++) begin
            applyRandom(1'b1);
        end
        waitDrain();

        $display("[TB] backpressure");
        ready_idx  = 0;
        ready_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyRandom(1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            applyRandom(1'b1);
        end
        waitDrain();
        ready_mode = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++) begin
            applyRandom(1'b0);
        end
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < STAGES + 2; i++) begin
            @(negedge clk);
            checkOutput("flushed_out_valid", 64'(out_valid), 64'(0));
            if (i == 0) begin
                checkOutput("in_ready_after_reset", 64'(in_ready), 64'(1));
            end
        end
        @(posedge clk);
        #1;
        applyStimulus(WIDTH'(16'h1234), WIDTH'(16'h1111), 1'b0, 1'b0,
                      mk(WIDTH'(16'h2345), 1'b0, 1'b0));
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        n_mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor. It is the sequential successor of the team's 4-bit ripple-carry and carry-lookahead adders.
- The WIDTH-bit operation is split into STAGES equal chunks. One chunk is resolved per pipeline stage, and the carry is registered between stages.
- Valid/ready handshake on both sides; one operation accepted per cycle.
- Sits between operand-issue logic and a result consumer in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0: A+B+cin; 1: A-B-cin (cin acts as borrow-in)
- cin  input  1  carry-in / borrow-in
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  add: carry-out; sub: borrow-out (1 when unsigned A < B+cin)
- overflow  output  1  signed overflow of the WIDTH-bit result

Behaviour:
- Reset: on a rising clk edge with rst_n=0, all stage valid bits clear. out_valid=0, sum=0, cout=0, overflow=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation: all in-flight operations are discarded with no output. Data registers may hold stale values, but output ports are forced to 0 while out_valid=0.
- Operand preparation at stage 0:
  - b_eff = sub ? ~b : b
  - c_in = sub ? ~cin : cin
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff, plus the carry registered by stage k-1 (c_in for k=0).
  - Registers the chunk result and the chunk carry-out.
  - Carries forward the unconsumed upper chunks of a/b_eff, the completed lower sum chunks, the sub flag, and the valid bit.
- Final stage output:
  - sum = concatenated chunks.
  - raw carry c = carry out of the MSB chunk; cout = sub ? ~c : c.
  - overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), using the sign bits of the delayed operands.
- Latency: exactly STAGES cycles from the accepting edge (in_valid && in_ready) to out_valid=1, provided the pipeline is not stalled.
- Handshake and stall:
  - advance = out_ready || !out_valid.
  - All stages shift only when advance=1; in_ready = advance (combinational from out_ready).
  - A bubble (in_valid=0 while advancing) enters as a valid=0 slot.
  - Throughput: 1 result per cycle when out_ready is held at 1.
- Stall hold: while out_valid=1 and out_ready=0, sum/cout/overflow/out_valid hold stable and no input is accepted.
- Simultaneous accept and drain: both happen in the same cycle; nothing is lost or duplicated.
- Ordering: results emerge strictly in acceptance order.
- Arithmetic is modulo 2^WIDTH; no saturation.
- STAGES=1: a single registered adder with latency 1.

Decomposition:
- Shared package adder_pkg:
  - typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} addsub_op_t
  - localparam function chunk_width(WIDTH, STAGES)
  - elaboration assertion that WIDTH % STAGES == 0
- Sub-module add_chunk: combinational CW-bit carry-lookahead chunk adder (inputs a, b, ci; outputs s, co). It is instantiated once per stage by a generate loop, and the pipeline registers live in pipelined_add_sub.

Test Plan:
- Add, no overflow: WIDTH=16, STAGES=4; a=0x00FF, b=0x0001, sub=0, cin=0, out_ready=1 -> exactly 4 cycles later out_valid=1, sum=0x0100, cout=0, overflow=0.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0, cin=0 -> sum=0x8000, cout=0, overflow=1. Separately, a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, overflow=0.
- Subtract with borrow:
  - a=0x0000, b=0x0001, sub=1, cin=0 -> sum=0xFFFF, cout=1, overflow=0.
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=0, overflow=1.
  - a=0x0005, b=0x0003, sub=1, cin=1 -> sum=0x0001, cout=0.
- Backpressure: 8 back-to-back random operations with out_ready toggling 1,0,0,1,... -> all 8 results correct and in order; outputs stable during stalls; in_ready=0 whenever out_valid=1 and out_ready=0.
- Reset mid-flight: accept 3 operations, assert rst_n=0 for 1 cycle on the 2nd cycle -> out_valid stays 0 for all of them, in_ready=1 after reset. A new operation 0x1234+0x1111 then yields 0x2345 after 4 cycles.
- Parameter sweep: STAGES=1, 2, 16 with WIDTH=16, plus WIDTH=32/STAGES=4, each against a reference model over 1000 random operations -> zero mismatches, latency equal to STAGES.
